// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline. It covers load-use, taken-branch squash,
// data-memory wait and HLT drain, and it holds the halt state and a saturating stall counter.
module hazard_stall_unit #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IFID_rs,
  input  logic [REG_W-1:0] IFID_rt,
  input  logic             IFID_uses_rt,
  input  logic             IFID_halt,
  input  logic [REG_W-1:0] IDEX_rd,
  input  logic             IDEX_memread,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic freeze;
  logic load_use;
  logic pc_we_c, ifid_we_c, ifid_flush_c, idex_bubble_c;
  logic exmem_we_c, memwb_bubble_c, halted_c;

  assign freeze   = mem_req & ~mem_ready;
  assign load_use = IDEX_memread & (IDEX_rd != '0) &
                    ((IDEX_rd == IFID_rs) | (IFID_uses_rt & (IDEX_rd == IFID_rt)));

  // Priority within RUN/DRAIN: memory freeze, then branch squash, then load-use, then HLT.
  always_comb begin
    pc_we_c        = 1'b0;
    ifid_we_c      = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_we_c     = 1'b0;
    memwb_bubble_c = 1'b0;
    halted_c       = 1'b0;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          memwb_bubble_c = 1'b1;
        end else if (branch_taken) begin
          pc_we_c       = 1'b1;
          ifid_we_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_we_c    = 1'b1;
        end else if (load_use) begin
          idex_bubble_c = 1'b1;
          exmem_we_c    = 1'b1;
        end else if (IFID_halt) begin
          ifid_we_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_we_c    = 1'b1;
          state_d       = ST_DRAIN;
          drain_cnt_d   = DRAIN_INIT;
        end else begin
          pc_we_c    = 1'b1;
          ifid_we_c  = 1'b1;
          exmem_we_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (freeze) begin
          memwb_bubble_c = 1'b1;
        end else if (branch_taken) begin
          // An older branch ahead of the HLT resolved taken, so the halt is cancelled.
          pc_we_c       = 1'b1;
          ifid_we_c     = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          exmem_we_c    = 1'b1;
          state_d       = ST_RUN;
        end else begin
          idex_bubble_c = 1'b1;
          exmem_we_c    = 1'b1;
          if (drain_cnt_q == 4'd0) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
      end
      ST_HALTED: begin
        halted_c = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && (freeze || (load_use && !branch_taken)) &&
        (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces every control low without waiting for a clock edge.
  assign pc_we        = pc_we_c & ~rst;
  assign ifid_we      = ifid_we_c & ~rst;
  assign ifid_flush   = ifid_flush_c & ~rst;
  assign idex_bubble  = idex_bubble_c & ~rst;
  assign exmem_we     = exmem_we_c & ~rst;
  assign memwb_bubble = memwb_bubble_c & ~rst;
  assign halted       = halted_c & ~rst;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit: each vector pushes its hand-computed outputs into a
// queue, and a monitor pops and compares them once per cycle on the falling clock edge.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  IFID_rs, IFID_rt, IDEX_rd;
  logic        IFID_uses_rt, IFID_halt, IDEX_memread, branch_taken, mem_req, mem_ready;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, halted;
  logic [15:0] stall_count;

  typedef struct {
    logic [6:0]  ctl;
    logic [15:0] cnt;
    string       name;
  } expect_t;

  expect_t expQ[$];
  int vectorsApplied = 0;
  int miscompares    = 0;

  // Output control patterns, packed as {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, halted}
  localparam logic [6:0] O_ZERO = 7'b000_0000;
  localparam logic [6:0] O_DEF  = 7'b110_0100;
  localparam logic [6:0] O_LU   = 7'b000_1100;
  localparam logic [6:0] O_FRZ  = 7'b000_0010;
  localparam logic [6:0] O_BR   = 7'b111_1100;
  localparam logic [6:0] O_HLT  = 7'b011_1100;
  localparam logic [6:0] O_DRN  = 7'b000_1100;
  localparam logic [6:0] O_HALT = 7'b000_0001;

  hazard_stall_unit #(.REG_W(4), .DRAIN_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_uses_rt(IFID_uses_rt), .IFID_halt(IFID_halt),
    .IDEX_rd(IDEX_rd), .IDEX_memread(IDEX_memread), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_we(exmem_we), .memwb_bubble(memwb_bubble), .halted(halted), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
  task automatic applyStimulus(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                               input logic usesRt, input logic hlt, input logic [3:0] rd,
                               input logic memRead, input logic br, input logic req,
                               input logic rdy, input logic [6:0] ctl, input logic [15:0] cnt,
                               input string name);
    expect_t e;
    @(posedge clk);
    #1;
    rst = r; IFID_rs = rs; IFID_rt = rt; IFID_uses_rt = usesRt; IFID_halt = hlt;
    IDEX_rd = rd; IDEX_memread = memRead; branch_taken = br; mem_req = req; mem_ready = rdy;
    e.ctl = ctl; e.cnt = cnt; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [6:0] got;
    got = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble, halted};
    vectorsApplied++;
    if (got !== e.ctl || stall_count !== e.cnt) begin
      miscompares++;
      $display("[TB] FAIL %s: ctl got %b want %b, stall_count got %h want %h",
               e.name, got, e.ctl, stall_count, e.cnt);
    end
  endtask

  // Monitor: outputs are combinational, so every queued vector is checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    rst = 1'b1; IFID_rs = 0; IFID_rt = 0; IFID_uses_rt = 0; IFID_halt = 0;
    IDEX_rd = 0; IDEX_memread = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;

    //            rst rs rt ur hl rd mr br rq ry  ctl     cnt
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 16'd0, "reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd0, "idle");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 0, 0, O_LU,   16'd0, "loaduse_rs");
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd1, "after_lu");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_DEF,  16'd1, "rd_zero");
    applyStimulus(0, 5, 3, 0, 0, 3, 1, 0, 0, 0, O_DEF,  16'd1, "rt_unused");
    applyStimulus(0, 5, 3, 1, 0, 3, 1, 0, 0, 0, O_LU,   16'd1, "loaduse_rt");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd2, "after_lu_rt");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1, 0, O_FRZ,  16'd2, "freeze1");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1, 0, O_FRZ,  16'd3, "freeze2");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1, 0, O_FRZ,  16'd4, "freeze3");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1, 1, O_LU,   16'd5, "ready_lu");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd6, "after_freeze_lu");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1, 0, O_FRZ,  16'd6, "freeze_nolu");
    applyStimulus(0, 4, 0, 0, 0, 3, 0, 0, 1, 1, O_DEF,  16'd7, "ready_nolu");
    applyStimulus(0, 3, 0, 0, 1, 3, 1, 1, 0, 0, O_BR,   16'd7, "branch_over_all");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd7, "after_branch");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_HLT,  16'd7, "hlt_decode");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN,  16'd7, "drain1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN,  16'd7, "drain2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  16'd7, "drain_frz1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  16'd7, "drain_frz2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN,  16'd7, "drain3");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN,  16'd7, "drain4");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_HALT, 16'd7, "halted");
    applyStimulus(0, 3, 0, 0, 0, 3, 1, 0, 1, 0, O_HALT, 16'd7, "halted_frz");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, O_HALT, 16'd7, "halted_br");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 16'd0, "rst_halted");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd0, "run_after_rst");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_HLT,  16'd0, "hlt2");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN,  16'd0, "drain_b1");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,   16'd0, "drain_branch");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd0, "run_after_cancel");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  16'd0, "frz_pre_rst");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_ZERO, 16'd0, "rst_mid_freeze");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd0, "run_after_rst2");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, O_HLT,  16'd0, "hlt3");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRN,  16'd0, "drain_c1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_ZERO, 16'd0, "rst_mid_drain");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'd0, "run_after_rst3");

    // Saturation: 2^16+5 frozen cycles in RUN from a counter of zero, then confirm it sticks.
    @(posedge clk);
    #1;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 65541 - 1; i++) @(posedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  16'hFFFF, "sat_freeze");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ,  16'hFFFF, "sat_hold");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF,  16'hFFFF, "sat_idle");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain_queue: pending %0d want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
